l1ca_signal_gen: RTL

- Synthetic GPS L1 C/A transmitter: generates the 1-bit sampled IF stream that the search and fine-search blocks consume on signal_in.
- Used for closed-loop bench and FPGA self-test of acquisition.
- Produces C/A code for a selected PRN at a programmable code phase, code rate and carrier (Doppler) frequency, modulated with a 50 bps nav bit stream.
- Output = sign of data * code * carrier, as XOR of sign bits.

---
 rtl/l1ca_signal_gen.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/l1ca_signal_gen.sv
// Synthetic GPS L1 C/A transmitter: PRN code x 50 bps nav data x carrier sign,
// emitted as a registered 1-bit IF sample stream for acquisition self-test.
module l1ca_signal_gen #(
   parameter int ACC_W          = 32,
   parameter int EPOCHS_PER_BIT = 20
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             stop,
   input  logic [4:0]       sv,
   input  logic [9:0]       code_phase_init,
   input  logic [ACC_W-1:0] code_inc,
   input  logic [ACC_W-1:0] carr_inc,
   input  logic             nav_bit_in,
   output logic             signal_out,
   output logic             epoch,
   output logic             nav_strobe,
   output logic             busy
);

   localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SLEW = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [4:0]       sv_q, sv_d;
   logic [ACC_W-1:0] code_inc_q, code_inc_d;
   logic [ACC_W-1:0] carr_inc_q, carr_inc_d;
   logic [ACC_W-1:0] code_acc_q, code_acc_d;
   logic [ACC_W-1:0] carr_acc_q, carr_acc_d;
   logic [10:1]      g1_q, g1_d;
   logic [10:1]      g2_q, g2_d;
   logic [9:0]       chip_cnt_q, chip_cnt_d;
   logic [9:0]       slew_cnt_q, slew_cnt_d;
   logic [EW-1:0]    epoch_cnt_q, epoch_cnt_d;
   logic             nav_bit_q, nav_bit_d;
   logic             signal_q, signal_d;
   logic             epoch_q, epoch_d;
   logic             strobe_q, strobe_d;

   logic [10:1]      g1_adv, g2_adv;
   logic [10:0]      g2_ext;
   logic [3:0]       tap_a, tap_b;
   logic             chip;
   logic [ACC_W:0]   code_sum;
   logic [9:0]       phase_eff;

   // G2 phase-select tap pairs (1-based stage numbers) for PRN 1..32.
   always_comb begin
      tap_a = 4'd2;
      tap_b = 4'd6;
      case (sv_q)
         5'd0:  begin tap_a = 4'd2; tap_b = 4'd6;  end
         5'd1:  begin tap_a = 4'd3; tap_b = 4'd7;  end
         5'd2:  begin tap_a = 4'd4; tap_b = 4'd8;  end
         5'd3:  begin tap_a = 4'd5; tap_b = 4'd9;  end
         5'd4:  begin tap_a = 4'd1; tap_b = 4'd9;  end
         5'd5:  begin tap_a = 4'd2; tap_b = 4'd10; end
         5'd6:  begin tap_a = 4'd1; tap_b = 4'd8;  end
         5'd7:  begin tap_a = 4'd2; tap_b = 4'd9;  end
         5'd8:  begin tap_a = 4'd3; tap_b = 4'd10; end
         5'd9:  begin tap_a = 4'd2; tap_b = 4'd3;  end
         5'd10: begin tap_a = 4'd3; tap_b = 4'd4;  end
         5'd11: begin tap_a = 4'd5; tap_b = 4'd6;  end
         5'd12: begin tap_a = 4'd6; tap_b = 4'd7;  end
         5'd13: begin tap_a = 4'd7; tap_b = 4'd8;  end
         5'd14: begin tap_a = 4'd8; tap_b = 4'd9;  end
         5'd15: begin tap_a = 4'd9; tap_b = 4'd10; end
         5'd16: begin tap_a = 4'd1; tap_b = 4'd4;  end
         5'd17: begin tap_a = 4'd2; tap_b = 4'd5;  end
         5'd18: begin tap_a = 4'd3; tap_b = 4'd6;  end
         5'd19: begin tap_a = 4'd4; tap_b = 4'd7;  end
         5'd20: begin tap_a = 4'd5; tap_b = 4'd8;  end
         5'd21: begin tap_a = 4'd6; tap_b = 4'd9;  end
         5'd22: begin tap_a = 4'd1; tap_b = 4'd3;  end
         5'd23: begin tap_a = 4'd4; tap_b = 4'd6;  end
         5'd24: begin tap_a = 4'd5; tap_b = 4'd7;  end
         5'd25: begin tap_a = 4'd6; tap_b = 4'd8;  end
         5'd26: begin tap_a = 4'd7; tap_b = 4'd9;  end
         5'd27: begin tap_a = 4'd8; tap_b = 4'd10; end
         5'd28: begin tap_a = 4'd1; tap_b = 4'd6;  end
         5'd29: begin tap_a = 4'd2; tap_b = 4'd7;  end
         5'd30: begin tap_a = 4'd3; tap_b = 4'd8;  end
         default: begin tap_a = 4'd4; tap_b = 4'd9; end
      endcase
   end

   assign g1_adv    = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
   assign g2_adv    = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
   assign g2_ext    = {g2_q, 1'b0};
   assign chip      = g1_q[10] ^ g2_ext[tap_a] ^ g2_ext[tap_b];
   assign code_sum  = {1'b0, code_acc_q} + {1'b0, code_inc_q};
   assign phase_eff = (code_phase_init == 10'd1023) ? 10'd0 : code_phase_init;

   always_comb begin
      state_d     = state_q;
      sv_d        = sv_q;
      code_inc_d  = code_inc_q;
      carr_inc_d  = carr_inc_q;
      code_acc_d  = code_acc_q;
      carr_acc_d  = carr_acc_q;
      g1_d        = g1_q;
      g2_d        = g2_q;
      chip_cnt_d  = chip_cnt_q;
      slew_cnt_d  = slew_cnt_q;
      epoch_cnt_d = epoch_cnt_q;
      nav_bit_d   = nav_bit_q;
      signal_d    = 1'b0;
      epoch_d     = 1'b0;
      strobe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sv_d        = sv;
               code_inc_d  = code_inc;
               carr_inc_d  = carr_inc;
               nav_bit_d   = nav_bit_in;
               g1_d        = '1;
               g2_d        = '1;
               chip_cnt_d  = '0;
               code_acc_d  = '0;
               carr_acc_d  = '0;
               epoch_cnt_d = '0;
               slew_cnt_d  = phase_eff;
               state_d     = (phase_eff == 10'd0) ? RUN : SLEW;
            end
         end
         SLEW: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               g1_d       = g1_adv;
               g2_d       = g2_adv;
               chip_cnt_d = chip_cnt_q + 10'd1;
               slew_cnt_d = slew_cnt_q - 10'd1;
               if (slew_cnt_q == 10'd1) state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               code_acc_d = code_sum[ACC_W-1:0];
               carr_acc_d = carr_acc_q + carr_inc_q;
               signal_d   = chip ^ nav_bit_q ^ carr_acc_q[ACC_W-1];
               if (code_sum[ACC_W]) begin
                  // Chip 1022 is the last of the epoch; the LFSRs restart from all ones.
                  if (chip_cnt_q == 10'd1022) begin
                     chip_cnt_d = '0;
                     g1_d       = '1;
                     g2_d       = '1;
                     epoch_d    = 1'b1;
                     if (epoch_cnt_q == EW'(EPOCHS_PER_BIT - 1)) begin
                        epoch_cnt_d = '0;
                        nav_bit_d   = nav_bit_in;
                        strobe_d    = 1'b1;
                     end else begin
                        epoch_cnt_d = epoch_cnt_q + 1'b1;
                     end
                  end else begin
                     chip_cnt_d = chip_cnt_q + 10'd1;
                     g1_d       = g1_adv;
                     g2_d       = g2_adv;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         sv_q        <= '0;
         code_inc_q  <= '0;
         carr_inc_q  <= '0;
         code_acc_q  <= '0;
         carr_acc_q  <= '0;
         g1_q        <= '1;
         g2_q        <= '1;
         chip_cnt_q  <= '0;
         slew_cnt_q  <= '0;
         epoch_cnt_q <= '0;
         nav_bit_q   <= 1'b0;
         signal_q    <= 1'b0;
         epoch_q     <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sv_q        <= sv_d;
         code_inc_q  <= code_inc_d;
         carr_inc_q  <= carr_inc_d;
         code_acc_q  <= code_acc_d;
         carr_acc_q  <= carr_acc_d;
         g1_q        <= g1_d;
         g2_q        <= g2_d;
         chip_cnt_q  <= chip_cnt_d;
         slew_cnt_q  <= slew_cnt_d;
         epoch_cnt_q <= epoch_cnt_d;
         nav_bit_q   <= nav_bit_d;
         signal_q    <= signal_d;
         epoch_q     <= epoch_d;
         strobe_q    <= strobe_d;
      end
   end

   assign signal_out = signal_q;
   assign epoch      = epoch_q;
   assign nav_strobe = strobe_q;
   assign busy       = (state_q != IDLE);

endmodule
